cpu_sequencer: RTL and testbench

- Multi-cycle control FSM for the 12-bit CPU datapath.
- Fetches 16-bit instructions over a req/ack instruction-memory port and holds each one in the instruction register (INST) for the decoder.
- Uses the decoder's control outputs (LD, MW, MD, HLT, BS, OFF) and the ALU flags to sequence the decode, execute, memory and writeback phases.
- Owns the PC, branch resolution, register-file write strobe and data-memory handshake.

---
 rtl/cpu_sequencer.sv | 135 +++++++++++++
 tb/tb_cpu_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 12-bit CPU: fetch, decode, execute,
// memory and writeback phases, plus PC, branch resolution and retire counting.
module cpu_sequencer #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            RUN,
   output logic            IMEM_REQ,
   output logic [PC_W-1:0] IMEM_ADDR,
   input  logic            IMEM_ACK,
   input  logic [15:0]     IMEM_RDATA,
   output logic [15:0]     INST,
   input  logic            DEC_LD,
   input  logic            DEC_MW,
   input  logic            DEC_MD,
   input  logic            DEC_HLT,
   input  logic [2:0]      DEC_BS,
   input  logic [5:0]      DEC_OFF,
   input  logic            ALU_Z,
   input  logic            ALU_N,
   output logic            DMEM_REQ,
   output logic            DMEM_WE,
   input  logic            DMEM_ACK,
   output logic            RF_WE,
   output logic [PC_W-1:0] PC,
   output logic            HALTED,
   output logic [2:0]      STATE,
   output logic [15:0]     RETIRED
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } state_t;

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_next, off_ext;
   logic [15:0]     inst_q, retired_q;
   logic            taken_q, taken_now, use_taken, retire;

   always_comb begin
      taken_now = 1'b0;
      case (DEC_BS)
         3'b000:  taken_now = ALU_Z;
         3'b001:  taken_now = !ALU_Z;
         3'b010:  taken_now = !ALU_N;
         3'b011:  taken_now = ALU_N;
         default: taken_now = 1'b0;
      endcase
   end

   // Branches retire straight out of EXEC, before the registered flag exists.
   assign use_taken = (state_q == EXEC) ? taken_now : taken_q;
   assign off_ext   = PC_W'($signed(DEC_OFF));
   assign pc_next   = pc_q + PC_ONE + (use_taken ? off_ext : '0);

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         IDLE:    if (RUN) state_d = FETCH;
         FETCH:   if (IMEM_ACK) state_d = DECODE;
         DECODE:  state_d = DEC_HLT ? HALT : EXEC;
         EXEC: begin
            if (DEC_MW || (DEC_MD && DEC_LD)) begin
               state_d = MEM;
            end else if (DEC_LD) begin
               state_d = WB;
            end else begin
               retire  = 1'b1;
               state_d = FETCH;
            end
         end
         // MW with LD is an illegal encoding and is handled as a plain store.
         MEM: begin
            if (DMEM_ACK) begin
               if (DEC_MW) begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = WB;
               end
            end
         end
         WB: begin
            retire  = 1'b1;
            state_d = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         retired_q <= '0;
         taken_q   <= 1'b0;
      end else begin
         if (state_q == FETCH && IMEM_ACK) inst_q <= IMEM_RDATA;
         if (state_q == EXEC) taken_q <= taken_now;
         if (retire) begin
            pc_q      <= pc_next;
            retired_q <= retired_q + 16'd1;
         end
      end
   end

   assign IMEM_REQ  = (state_q == FETCH);
   assign IMEM_ADDR = pc_q;
   assign INST      = inst_q;
   assign DMEM_REQ  = (state_q == MEM);
   assign DMEM_WE   = (state_q == MEM) && DEC_MW;
   assign RF_WE     = (state_q == WB);
   assign PC        = pc_q;
   assign HALTED    = (state_q == HALT);
   assign STATE     = state_q;
   assign RETIRED   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed instruction stream, retire and
// halt events checked by a monitor against queued hand-computed expectations.
module tb_cpu_sequencer;

   logic        CLK = 1'b0;
   logic        RST_N, RUN;
   logic        IMEM_REQ, IMEM_ACK, DMEM_REQ, DMEM_WE, DMEM_ACK, RF_WE, HALTED;
   logic [7:0]  IMEM_ADDR, PC;
   logic [15:0] IMEM_RDATA, INST, RETIRED;
   logic        DEC_LD, DEC_MW, DEC_MD, DEC_HLT, ALU_Z, ALU_N;
   logic [2:0]  DEC_BS, STATE;
   logic [5:0]  DEC_OFF;

   typedef struct {
      logic        isHalt;
      logic [7:0]  pc;
      logic [15:0] retired;
      logic [15:0] inst;
      logic [31:0] path;
      int          cycles;
      int          rfWe;
      int          dmemReq;
      logic        we;
   } expect_t;

   expect_t     sbQueue[$];
   int          errors = 0;
   int          checks = 0;
   int          imemDelay = 0, dmemDelay = 0, imemCnt = 0, dmemCnt = 0;
   logic        strayAck = 1'b0;
   logic [15:0] expRetired = 16'd0;
   logic [2:0]  lastSeen = 3'd0;

   logic [2:0]  monPrev = 3'd0;
   logic        monTrack = 1'b0;
   int          monCyc, monRf, monDm;
   logic [31:0] monPath;
   logic        monWe;

   cpu_sequencer #(.PC_W(8), .RESET_PC(8'd0)) dut (
      .CLK(CLK), .RST_N(RST_N), .RUN(RUN),
      .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
      .INST(INST), .DEC_LD(DEC_LD), .DEC_MW(DEC_MW), .DEC_MD(DEC_MD), .DEC_HLT(DEC_HLT),
      .DEC_BS(DEC_BS), .DEC_OFF(DEC_OFF), .ALU_Z(ALU_Z), .ALU_N(ALU_N),
      .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ACK(DMEM_ACK), .RF_WE(RF_WE),
      .PC(PC), .HALTED(HALTED), .STATE(STATE), .RETIRED(RETIRED)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: bound expired, got timeout, expected event (t=%0t)", name, $time);
   endtask

   // Memory responders act 1 time unit after the falling edge, after stimulus settles.
   always @(negedge CLK) begin
      #1;
      if (STATE == 3'd1) begin
         IMEM_ACK = (imemCnt >= imemDelay);
         imemCnt++;
      end else begin
         IMEM_ACK = strayAck;
         imemCnt  = 0;
      end
      if (STATE == 3'd4) begin
         DMEM_ACK = (dmemCnt >= dmemDelay);
         dmemCnt++;
      end else begin
         DMEM_ACK = strayAck;
         dmemCnt  = 0;
      end
   end

   task automatic scoreEvent(input logic haltEvent);
      expect_t e;
      if (sbQueue.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpected event: got retire/halt at PC=%0d, expected none", PC);
      end else begin
         e = sbQueue.pop_front();
         checkOutput("event kind", 32'(haltEvent), 32'(e.isHalt));
         checkOutput("pc", 32'(PC), 32'(e.pc));
         checkOutput("retired", 32'(RETIRED), 32'(e.retired));
         checkOutput("inst", 32'(INST), 32'(e.inst));
         checkOutput("state path", monPath, e.path);
         checkOutput("cycles", 32'(monCyc), 32'(e.cycles));
         checkOutput("rf_we cycles", 32'(monRf), 32'(e.rfWe));
         checkOutput("dmem_req cycles", 32'(monDm), 32'(e.dmemReq));
         checkOutput("dmem_we seen", 32'(monWe), 32'(e.we));
         if (haltEvent) checkOutput("halted", 32'(HALTED), 32'd1);
      end
   endtask

   // Monitor: traces each instruction from its FETCH and scores it when it retires or halts.
   always @(negedge CLK) begin
      if (!RST_N) begin
         monPrev  = 3'd0;
         monTrack = 1'b0;
      end else begin
         if (STATE == 3'd1 && monPrev != 3'd1) begin
            if (monTrack && (monPrev == 3'd3 || monPrev == 3'd4 || monPrev == 3'd5)) scoreEvent(1'b0);
            monTrack = 1'b1;
            monCyc   = 0;
            monPath  = 32'd0;
            monRf    = 0;
            monDm    = 0;
            monWe    = 1'b0;
         end
         if (monTrack) begin
            if (STATE != monPrev) monPath = {monPath[27:0], 1'b0, STATE};
            monCyc++;
            monRf += int'(RF_WE);
            monDm += int'(DMEM_REQ);
            monWe  = monWe | DMEM_WE;
            if (STATE == 3'd6 && monPrev != 3'd6) begin
               scoreEvent(1'b1);
               monTrack = 1'b0;
            end
         end
         monPrev = STATE;
      end
   end

   task automatic applyStimulus(input logic [7:0] fetchPc, input logic [15:0] word,
                                input logic ld, input logic mw, input logic md, input logic hlt,
                                input logic [2:0] bs, input logic [5:0] off, input logic z, input logic n,
                                input int iDelay, input int dDelay, input logic [7:0] expPc,
                                input logic [31:0] expPath, input int expCyc, input int expRf,
                                input int expDm, input logic expWe, input logic isHalt);
      expect_t e;
      int      budget = 0;
      bit      found  = 0;
      while (!found && budget < 200) begin
         @(negedge CLK);
         budget++;
         if (STATE == 3'd1 && lastSeen != 3'd1) found = 1;
         lastSeen = STATE;
      end
      if (!found) begin
         timeoutFail("fetch wait");
         return;
      end
      checkOutput("fetch addr", 32'(IMEM_ADDR), 32'(fetchPc));
      IMEM_RDATA = word;
      DEC_LD = ld; DEC_MW = mw; DEC_MD = md; DEC_HLT = hlt;
      DEC_BS = bs; DEC_OFF = off; ALU_Z = z; ALU_N = n;
      imemDelay = iDelay;
      dmemDelay = dDelay;
      strayAck  = 1'b0;
      if (!isHalt) expRetired = expRetired + 16'd1;
      e.isHalt = isHalt; e.pc = expPc; e.retired = expRetired; e.inst = word;
      e.path = expPath; e.cycles = expCyc; e.rfWe = expRf; e.dmemReq = expDm; e.we = expWe;
      sbQueue.push_back(e);
   endtask

   task automatic nopOp(input logic [7:0] fetchPc, input logic [2:0] bs, input logic [5:0] off,
                        input logic z, input logic n, input int iDelay, input logic [7:0] nextPc);
      applyStimulus(fetchPc, {8'h70, fetchPc}, 1'b0, 1'b0, 1'b0, 1'b0, bs, off, z, n,
                    iDelay, 0, nextPc, 32'h123, 3 + iDelay, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic aluOp(input logic [7:0] fetchPc, input logic [2:0] bs, input logic [5:0] off,
                        input logic z, input logic [7:0] nextPc);
      applyStimulus(fetchPc, {8'h10, fetchPc}, 1'b1, 1'b0, 1'b0, 1'b0, bs, off, z, 1'b0,
                    0, 0, nextPc, 32'h1235, 4, 1, 0, 1'b0, 1'b0);
   endtask

   task automatic loadOp(input logic [7:0] fetchPc, input int dDelay);
      applyStimulus(fetchPc, {8'h20, fetchPc}, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 6'd0, 1'b0, 1'b0,
                    0, dDelay, fetchPc + 8'd1, 32'h12345, 5 + dDelay, 1, 1 + dDelay, 1'b0, 1'b0);
   endtask

   task automatic storeOp(input logic [7:0] fetchPc, input logic ld);
      applyStimulus(fetchPc, {8'h30, fetchPc}, ld, 1'b1, 1'b0, 1'b0, 3'b100, 6'd0, 1'b0, 1'b0,
                    0, 0, fetchPc + 8'd1, 32'h1234, 4, 0, 1, 1'b1, 1'b0);
   endtask

   task automatic haltOp(input logic [7:0] fetchPc);
      applyStimulus(fetchPc, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 6'd0, 1'b0, 1'b0,
                    0, 0, fetchPc, 32'h126, 3, 0, 0, 1'b0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int budget;
      RST_N = 1'b0; RUN = 1'b0; IMEM_ACK = 1'b0; DMEM_ACK = 1'b0; IMEM_RDATA = 16'h0;
      DEC_LD = 1'b0; DEC_MW = 1'b0; DEC_MD = 1'b0; DEC_HLT = 1'b0;
      DEC_BS = 3'b100; DEC_OFF = 6'd0; ALU_Z = 1'b0; ALU_N = 1'b0;
      repeat (2) @(negedge CLK);
      checkOutput("reset state", 32'(STATE), 32'd0);
      checkOutput("reset pc", 32'(PC), 32'd0);
      checkOutput("reset inst", 32'(INST), 32'd0);
      checkOutput("reset retired", 32'(RETIRED), 32'd0);
      checkOutput("reset strobes", 32'({IMEM_REQ, DMEM_REQ, DMEM_WE, RF_WE, HALTED}), 32'd0);
      RST_N = 1'b1;
      @(negedge CLK);
      checkOutput("idle without run", 32'(STATE), 32'd0);
      RUN = 1'b1;

      aluOp(8'd0, 3'b100, 6'd0, 1'b0, 8'd1);
      RUN = 1'b0;
      loadOp(8'd1, 3);
      storeOp(8'd2, 1'b1);
      nopOp(8'd3, 3'b100, 6'd0, 1'b0, 1'b0, 2, 8'd4);
      nopOp(8'd4, 3'b100, 6'd0, 1'b0, 1'b0, 0, 8'd5);
      nopOp(8'd5, 3'b000, 6'b111100, 1'b1, 1'b0, 0, 8'd2);
      nopOp(8'd2, 3'b001, 6'd2, 1'b0, 1'b0, 0, 8'd5);
      nopOp(8'd5, 3'b000, 6'b111100, 1'b0, 1'b0, 0, 8'd6);
      nopOp(8'd6, 3'b010, 6'd7, 1'b0, 1'b1, 0, 8'd7);
      nopOp(8'd7, 3'b011, 6'd20, 1'b0, 1'b1, 0, 8'd28);
      nopOp(8'd28, 3'b010, 6'b100000, 1'b0, 1'b0, 0, 8'd253);
      nopOp(8'd253, 3'b100, 6'd9, 1'b1, 1'b0, 0, 8'd254);
      nopOp(8'd254, 3'b101, 6'd5, 1'b1, 1'b1, 0, 8'd255);
      nopOp(8'd255, 3'b100, 6'd0, 1'b0, 1'b0, 0, 8'd0);
      aluOp(8'd0, 3'b000, 6'd1, 1'b1, 8'd2);
      nopOp(8'd2, 3'b111, 6'd3, 1'b1, 1'b1, 0, 8'd3);
      strayAck = 1'b1;
      haltOp(8'd3);

      budget = 0;
      while (STATE != 3'd6 && budget < 50) begin
         @(negedge CLK);
         budget++;
      end
      if (STATE != 3'd6) timeoutFail("halt wait");
      @(negedge CLK);
      checkOutput("scoreboard drained", 32'(sbQueue.size()), 32'd0);

      for (int i = 0; i < 6; i++) begin
         RUN      = i[0];
         strayAck = ~i[0];
         @(negedge CLK);
         checkOutput("halt state", 32'(STATE), 32'd6);
         checkOutput("halt quiet", 32'({IMEM_REQ, DMEM_REQ, DMEM_WE, RF_WE, HALTED}), 32'd1);
         checkOutput("halt pc", 32'(PC), 32'd3);
         checkOutput("halt retired", 32'(RETIRED), 32'(expRetired));
      end
      strayAck = 1'b0;
      RUN      = 1'b0;
      #2 RST_N = 1'b0;
      #1;
      checkOutput("halt reset state", 32'(STATE), 32'd0);
      checkOutput("halt reset pc", 32'(PC), 32'd0);
      checkOutput("halt reset retired", 32'(RETIRED), 32'd0);
      checkOutput("halt reset halted", 32'(HALTED), 32'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      checkOutput("idle after reset", 32'(STATE), 32'd0);

      imemDelay = 20;
      RUN = 1'b1;
      @(negedge CLK);
      checkOutput("fetch pending state", 32'(STATE), 32'd1);
      checkOutput("fetch pending req", 32'(IMEM_REQ), 32'd1);
      RUN = 1'b0;
      #2 RST_N = 1'b0;
      #1;
      checkOutput("req dropped by reset", 32'(IMEM_REQ), 32'd0);
      checkOutput("state after mid-fetch reset", 32'(STATE), 32'd0);
      IMEM_RDATA = 16'hBEEF;
      strayAck   = 1'b1;
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      checkOutput("late ack ignored inst", 32'(INST), 32'd0);
      checkOutput("late ack ignored state", 32'(STATE), 32'd0);
      strayAck = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
